td4_run_ctrl: RTL and testbench

TD4_RUN_CTRL -- requirements
Module: td4_run_ctrl

---
 rtl/td4_pkg.sv | 26 ++
 rtl/td4_prog_ram.sv | 44 ++++
 rtl/td4_run_ctrl.sv | 140 ++++++++++++++
 tb/tb_td4_run_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/td4_pkg.sv
// Shared widths, host command encodings and run-controller state encoding for the TD4 debug block.
package td4_pkg;

  localparam int unsigned AddrWidth  = 4;
  localparam int unsigned InstrWidth = 8;
  localparam int unsigned Depth      = 1 << AddrWidth;

  typedef enum logic [2:0] {
    CmdNop      = 3'd0,
    CmdWrite    = 3'd1,
    CmdRead     = 3'd2,
    CmdRun      = 3'd3,
    CmdStep     = 3'd4,
    CmdHalt     = 3'd5,
    CmdSetbp    = 3'd6,
    CmdResetCpu = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {
    StLoad = 2'd0,
    StHalt = 2'd1,
    StRun  = 2'd2,
    StStep = 2'd3
  } state_e;

endpackage

// File: rtl/td4_prog_ram.sv
// 16x8 program store: one write port, asynchronous CPU fetch port, registered host read port.
module td4_prog_ram
  import td4_pkg::*;
#(
  parameter logic [InstrWidth-1:0] MEM_INIT = 8'h00
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  we,
  input  logic [AddrWidth-1:0]  waddr,
  input  logic [InstrWidth-1:0] wdata,
  input  logic [AddrWidth-1:0]  fetch_addr,
  output logic [InstrWidth-1:0] fetch_data,
  input  logic                  rd_en,
  input  logic [AddrWidth-1:0]  rd_addr,
  output logic [InstrWidth-1:0] rd_data
);

  logic [InstrWidth-1:0] mem_q [Depth];
  logic [InstrWidth-1:0] rd_data_q;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= MEM_INIT;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  // A fetch racing a write to the same word sees the old contents.
  assign fetch_data = mem_q[fetch_addr];
  assign rd_data    = rd_data_q;

endmodule

// File: rtl/td4_run_ctrl.sv
// Host-facing run controller for a TD4 CPU: program load, run/step/halt, breakpoint, cycle count.
module td4_run_ctrl
  import td4_pkg::*;
#(
  parameter logic [InstrWidth-1:0] MEM_INIT = 8'h00
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  host_cmd_valid,
  output logic                  host_cmd_ready,
  input  logic [2:0]            host_cmd,
  input  logic [AddrWidth-1:0]  host_addr,
  input  logic [InstrWidth-1:0] host_wdata,
  output logic                  host_rsp_valid,
  output logic [InstrWidth-1:0] host_rdata,
  input  logic [AddrWidth-1:0]  cpu_addr,
  output logic [InstrWidth-1:0] cpu_instr,
  output logic                  cpu_en,
  output logic                  cpu_n_reset,
  output logic [1:0]            state,
  output logic                  bp_hit,
  output logic [7:0]            exec_count
);

  state_e               state_q, state_d;
  cmd_e                 cmd;
  logic                 acc;
  logic                 halt_acc;
  logic                 bp_match;
  logic                 first_run_q;
  logic                 cpu_n_reset_q;
  logic                 rsp_valid_q;
  logic                 bp_en_q, bp_hit_q;
  logic [AddrWidth-1:0] bp_addr_q;
  logic [7:0]           exec_count_q;

  assign cmd      = cmd_e'(host_cmd);
  assign acc      = host_cmd_valid & host_cmd_ready;
  assign halt_acc = acc & (cmd == CmdHalt);
  // The first RUN cycle always executes so a resume can step off a breakpoint.
  assign bp_match = (state_q == StRun) & ~first_run_q & bp_en_q & (cpu_addr == bp_addr_q);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= StLoad;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoad: begin
        if (acc && cmd == CmdRun)  state_d = StRun;
        if (acc && cmd == CmdStep) state_d = StStep;
      end
      StHalt: begin
        if (acc && cmd == CmdRun)      state_d = StRun;
        if (acc && cmd == CmdStep)     state_d = StStep;
        if (acc && cmd == CmdResetCpu) state_d = StLoad;
      end
      StRun: begin
        if (bp_match || halt_acc) state_d = StHalt;
      end
      StStep: begin
        state_d = StHalt;
        if (acc && cmd == CmdRun)      state_d = StRun;
        if (acc && cmd == CmdStep)     state_d = StStep;
        if (acc && cmd == CmdResetCpu) state_d = StLoad;
      end
      default: state_d = StLoad;
    endcase
  end

  always_comb begin
    host_cmd_ready = 1'b1;
    cpu_en         = 1'b0;
    unique case (state_q)
      StRun: begin
        host_cmd_ready = (cmd == CmdHalt) || (cmd == CmdNop);
        cpu_en         = ~(bp_match | halt_acc);
      end
      StStep:  cpu_en = 1'b1;
      default: cpu_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cpu_n_reset_q <= 1'b0;
      first_run_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      bp_en_q       <= 1'b0;
      bp_addr_q     <= '0;
      bp_hit_q      <= 1'b0;
      exec_count_q  <= '0;
    end else begin
      cpu_n_reset_q <= (state_d != StLoad);
      first_run_q   <= (state_d == StRun) && (state_q != StRun);
      rsp_valid_q   <= acc && (cmd == CmdRead);
      if (acc && cmd == CmdSetbp) begin
        bp_addr_q <= host_addr;
        bp_en_q   <= host_wdata[0];
      end
      if (bp_match) begin
        bp_hit_q <= 1'b1;
      end else if (acc && (cmd == CmdRun || cmd == CmdStep || cmd == CmdResetCpu)) begin
        bp_hit_q <= 1'b0;
      end
      if (acc && cmd == CmdResetCpu) begin
        exec_count_q <= '0;
      end else if (cpu_en && exec_count_q != 8'hFF) begin
        exec_count_q <= exec_count_q + 8'd1;
      end
    end
  end

  td4_prog_ram #(
    .MEM_INIT (MEM_INIT)
  ) u_prog_ram (
    .clk        (clk),
    .n_reset    (n_reset),
    .we         (acc && cmd == CmdWrite),
    .waddr      (host_addr),
    .wdata      (host_wdata),
    .fetch_addr (cpu_addr),
    .fetch_data (cpu_instr),
    .rd_en      (acc && cmd == CmdRead),
    .rd_addr    (host_addr),
    .rd_data    (host_rdata)
  );

  assign host_rsp_valid = rsp_valid_q;
  assign cpu_n_reset    = cpu_n_reset_q;
  assign state          = state_q;
  assign bp_hit         = bp_hit_q;
  assign exec_count     = exec_count_q;

endmodule

// File: tb/tb_td4_run_ctrl.sv
// Directed bench for td4_run_ctrl with a trivial PC-increment CPU model driving cpu_addr.
module tb_td4_run_ctrl;

  localparam logic [7:0] Init = 8'h5A;
  localparam logic [2:0] NOP = 3'd0, WRITE = 3'd1, READ = 3'd2, RUN = 3'd3;
  localparam logic [2:0] STEP = 3'd4, HALT = 3'd5, SETBP = 3'd6, RESET_CPU = 3'd7;

  logic       clk = 1'b0;
  logic       n_reset;
  logic       host_cmd_valid, host_cmd_ready;
  logic [2:0] host_cmd;
  logic [3:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_rsp_valid;
  logic [7:0] host_rdata;
  logic [3:0] pc;
  logic [7:0] cpu_instr;
  logic       cpu_en, cpu_n_reset;
  logic [1:0] state;
  logic       bp_hit;
  logic [7:0] exec_count;
  logic [7:0] prog [16];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  td4_run_ctrl #(
    .MEM_INIT (Init)
  ) dut (
    .clk            (clk),
    .n_reset        (n_reset),
    .host_cmd_valid (host_cmd_valid),
    .host_cmd_ready (host_cmd_ready),
    .host_cmd       (host_cmd),
    .host_addr      (host_addr),
    .host_wdata     (host_wdata),
    .host_rsp_valid (host_rsp_valid),
    .host_rdata     (host_rdata),
    .cpu_addr       (pc),
    .cpu_instr      (cpu_instr),
    .cpu_en         (cpu_en),
    .cpu_n_reset    (cpu_n_reset),
    .state          (state),
    .bp_hit         (bp_hit),
    .exec_count     (exec_count)
  );

  // Minimal CPU: program counter advances on every enabled edge.
  always_ff @(posedge clk or negedge cpu_n_reset) begin
    if (!cpu_n_reset) pc <= 4'd0;
    else if (cpu_en)  pc <= pc + 4'd1;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] c, input logic [3:0] a, input logic [7:0] d);
    host_cmd_valid = 1'b1;
    host_cmd       = c;
    host_addr      = a;
    host_wdata     = d;
  endtask

  task automatic clear();
    host_cmd_valid = 1'b0;
    host_cmd       = NOP;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] c, input logic [3:0] a, input logic [7:0] d);
    drive(c, a, d);
    tick();
    clear();
  endtask

  initial begin
    prog = '{8'hB7, 8'h01, 8'hE1, 8'h01, 8'hE3, 8'hB6, 8'h01, 8'hE6,
             8'h01, 8'hE8, 8'hB0, 8'hB4, 8'h01, 8'hEA, 8'hB8, 8'hFF};
    n_reset = 1'b0;
    host_cmd_valid = 1'b0;
    host_cmd = NOP;
    host_addr = 4'd0;
    host_wdata = 8'd0;
    #12;
    chk("rst_state", state, 8'd0);
    chk("rst_cpu_n_reset", cpu_n_reset, 8'd0);
    chk("rst_cpu_en", cpu_en, 8'd0);
    chk("rst_rsp_valid", host_rsp_valid, 8'd0);
    chk("rst_rdata", host_rdata, 8'd0);
    chk("rst_bp_hit", bp_hit, 8'd0);
    chk("rst_exec", exec_count, 8'd0);
    chk("rst_instr", cpu_instr, Init);
    n_reset = 1'b1;
    tick();

    // Write then read back in LOAD
    issue(WRITE, 4'h3, 8'hB5);
    issue(READ, 4'h3, 8'h00);
    chk("rd_valid", host_rsp_valid, 8'd1);
    chk("rd_data", host_rdata, 8'hB5);
    tick();
    chk("rd_pulse_end", host_rsp_valid, 8'd0);
    chk("load_state", state, 8'd0);

    // Fetch of a word being written returns the old word
    drive(WRITE, 4'h0, 8'h11);
    #1 chk("fetch_old", cpu_instr, Init);
    tick();
    clear();
    chk("fetch_new", cpu_instr, 8'h11);

    for (int i = 0; i < 16; i++) issue(WRITE, 4'(i), prog[i]);
    chk("prog_fetch0", cpu_instr, 8'hB7);

    // RUN releases the CPU and enables it at the same edge
    issue(RUN, 4'h0, 8'h00);
    chk("run_state", state, 8'd2);
    chk("run_cpu_n_reset", cpu_n_reset, 8'd1);
    chk("run_cpu_en", cpu_en, 8'd1);
    chk("run_exec0", exec_count, 8'd0);
    repeat (3) tick();
    chk("run_exec3", exec_count, 8'd3);
    chk("run_instr3", cpu_instr, 8'h01);

    drive(WRITE, 4'h0, 8'h00);
    #1 chk("run_write_ready", host_cmd_ready, 8'd0);
    tick();
    clear();
    chk("run_exec4", exec_count, 8'd4);
    drive(HALT, 4'h0, 8'h00);
    #1 chk("halt_ready", host_cmd_ready, 8'd1);
    chk("halt_cpu_en", cpu_en, 8'd0);
    tick();
    clear();
    chk("halt_state", state, 8'd1);
    chk("halt_exec", exec_count, 8'd4);

    // Single step from HALT
    issue(STEP, 4'h0, 8'h00);
    chk("step_state", state, 8'd3);
    chk("step_cpu_en", cpu_en, 8'd1);
    tick();
    chk("step_back_halt", state, 8'd1);
    chk("step_cpu_en_off", cpu_en, 8'd0);
    chk("step_exec", exec_count, 8'd5);
    chk("step_pc", pc, 8'd5);
    issue(READ, 4'h0, 8'h00);
    chk("rejected_write", host_rdata, 8'hB7);

    // Breakpoint at 5
    issue(RESET_CPU, 4'h0, 8'h00);
    chk("rcpu_state", state, 8'd0);
    chk("rcpu_n_reset", cpu_n_reset, 8'd0);
    chk("rcpu_exec", exec_count, 8'd0);
    issue(SETBP, 4'h5, 8'h01);
    issue(RUN, 4'h0, 8'h00);
    repeat (5) tick();
    chk("bp_addr", pc, 8'd5);
    chk("bp_cpu_en", cpu_en, 8'd0);
    tick();
    chk("bp_state", state, 8'd1);
    chk("bp_hit", bp_hit, 8'd1);
    chk("bp_exec", exec_count, 8'd5);
    issue(RUN, 4'h0, 8'h00);
    chk("resume_bp_clr", bp_hit, 8'd0);
    chk("resume_cpu_en", cpu_en, 8'd1);
    tick();
    chk("resume_pc", pc, 8'd6);

    // HALT coincident with breakpoint match
    repeat (15) tick();
    drive(HALT, 4'h0, 8'h00);
    #1 chk("coinc_cpu_en", cpu_en, 8'd0);
    tick();
    clear();
    chk("coinc_state", state, 8'd1);
    chk("coinc_bp_hit", bp_hit, 8'd1);
    chk("coinc_exec", exec_count, 8'h15);

    // Saturation
    issue(SETBP, 4'h5, 8'h00);
    issue(RUN, 4'h0, 8'h00);
    repeat (300) tick();
    chk("sat_exec", exec_count, 8'hFF);
    chk("sat_state", state, 8'd2);

    // Asynchronous reset mid-RUN
    #2 n_reset = 1'b0;
    #1;
    chk("arst_state", state, 8'd0);
    chk("arst_cpu_en", cpu_en, 8'd0);
    chk("arst_exec", exec_count, 8'd0);
    chk("arst_instr", cpu_instr, Init);
    #2 n_reset = 1'b1;
    tick();
    issue(READ, 4'h3, 8'h00);
    chk("arst_mem", host_rdata, Init);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
